// File: rtl/rv32i_pkg.sv
// Shared constants and types for the RV32I front end.
package rv32i_pkg;

   localparam logic [31:0] RV32I_NOP        = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic {
      FETCH_RUN   = 1'b0,
      FETCH_FAULT = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/rv32i_fetch_fifo.sv
// Prefetch FIFO with a registered head word; the head holds its last value when empty.
module rv32i_fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 65
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     empty_o,
   output logic                     full_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic             do_pop_s, do_push_s;

   // Pointer/count update and next head word selection.
   always_comb begin
      do_pop_s  = pop_i && (count_q != CNT_ZERO);
      do_push_s = push_i && ((count_q != CNT_FULL) || do_pop_s);
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_q;
      rdata_d   = rdata_q;
      if (flush_i) begin
         rd_ptr_d = {PW{1'b0}};
         wr_ptr_d = {PW{1'b0}};
         count_d  = CNT_ZERO;
      end else begin
         rd_ptr_d = rd_ptr_q + PW'(do_pop_s);
         wr_ptr_d = wr_ptr_q + PW'(do_push_s);
         count_d  = count_q + CW'(do_push_s) - CW'(do_pop_s);
         // A push into an otherwise-empty FIFO becomes the head directly.
         if ((count_q - CW'(do_pop_s)) != CNT_ZERO) begin
            rdata_d = mem_q[rd_ptr_d];
         end else if (do_push_s) begin
            rdata_d = wdata_i;
         end else begin
            rdata_d = rdata_q;
         end
      end
   end

   // Control and head registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr_q <= {PW{1'b0}};
         wr_ptr_q <= {PW{1'b0}};
         count_q  <= CNT_ZERO;
         rdata_q  <= {WIDTH{1'b0}};
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         rdata_q  <= rdata_d;
      end
   end

   // Storage array.
   always_ff @(posedge clk) begin
      if (do_push_s && !flush_i) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   assign rdata_o = rdata_q;
   assign count_o = count_q;
   assign empty_o = (count_q == CNT_ZERO);
   assign full_o  = (count_q == CNT_FULL);

endmodule

// File: rtl/rv32i_fetch_unit.sv
// RV32I instruction fetch: PC, credit-limited memory requests, prefetch FIFO, redirect flush.
module rv32i_fetch_unit
   import rv32i_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC),
   parameter int                    FIFO_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [ADDR_WIDTH-1:0] imem_req_addr,
   input  logic                  imem_rsp_valid,
   input  logic [DATA_WIDTH-1:0] imem_rsp_data,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  if_valid,
   input  logic                  if_ready,
   output logic [DATA_WIDTH-1:0] if_instr,
   output logic [ADDR_WIDTH-1:0] if_pc,
   output logic                  if_misaligned
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int SW = CW + 2;
   localparam int EW = DATA_WIDTH + ADDR_WIDTH + 1;
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

   fetch_state_e          state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d, resp_pc_q, resp_pc_d;
   logic [CW-1:0]         outst_q, outst_d, drop_q, drop_d;
   logic                  fault_pend_q, fault_pend_d;

   logic [CW-1:0]         fifo_count_s;
   logic                  fifo_empty_s, fifo_full_s, fifo_push_s;
   logic [EW-1:0]         fifo_wdata_s, fifo_rdata_s;
   logic                  pop_s, rsp_drop_s, rsp_keep_s, marker_push_s;
   logic                  accept_s, misaligned_s;
   logic [SW-1:0]         credit_used_s;

   // Request credit, response routing and FIFO write data.
   always_comb begin
      pop_s         = !fifo_empty_s && if_ready;
      rsp_drop_s    = imem_rsp_valid && (drop_q != CNT_ZERO);
      rsp_keep_s    = imem_rsp_valid && (drop_q == CNT_ZERO) && !redirect_valid
                      && (!fifo_full_s || pop_s);
      marker_push_s = (state_q == FETCH_FAULT) && fault_pend_q && (drop_q == CNT_ZERO)
                      && !redirect_valid;
      // A slot freed by this cycle's pop is already counted as free.
      credit_used_s = SW'(outst_q) + SW'(fifo_count_s) + SW'(drop_q) - SW'(pop_s);
      imem_req_valid = reset_n && (state_q == FETCH_RUN) && !redirect_valid
                       && (credit_used_s < SW'(FIFO_DEPTH));
      accept_s      = imem_req_valid && imem_req_ready;
      misaligned_s  = (redirect_pc[1:0] != 2'b00);
      fifo_push_s   = rsp_keep_s || marker_push_s;
      if (marker_push_s) begin
         fifo_wdata_s = {1'b1, resp_pc_q, DATA_WIDTH'(RV32I_NOP)};
      end else begin
         fifo_wdata_s = {1'b0, resp_pc_q, imem_rsp_data};
      end
   end

   // Next-state logic for the FSM, PCs and in-flight counters.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      resp_pc_d    = resp_pc_q;
      drop_d       = drop_q;
      fault_pend_d = fault_pend_q;
      outst_d      = outst_q + CW'(accept_s) - CW'(imem_rsp_valid);

      case (state_q)
         FETCH_RUN, FETCH_FAULT: begin
            if (redirect_valid) begin
               state_d = misaligned_s ? FETCH_FAULT : FETCH_RUN;
            end else begin
               state_d = state_q;
            end
         end
         default: state_d = FETCH_RUN;
      endcase

      if (redirect_valid) begin
         // Every request still in flight after this cycle is stale.
         pc_d         = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
         resp_pc_d    = redirect_pc;
         drop_d       = outst_q - CW'(imem_rsp_valid);
         fault_pend_d = misaligned_s;
      end else begin
         pc_d         = accept_s ? (pc_q + ADDR_WIDTH'(3'd4)) : pc_q;
         resp_pc_d    = rsp_keep_s ? (resp_pc_q + ADDR_WIDTH'(3'd4)) : resp_pc_q;
         drop_d       = drop_q - CW'(rsp_drop_s);
         fault_pend_d = marker_push_s ? 1'b0 : fault_pend_q;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= FETCH_RUN;
         pc_q         <= RESET_PC;
         resp_pc_q    <= RESET_PC;
         outst_q      <= CNT_ZERO;
         drop_q       <= CNT_ZERO;
         fault_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         resp_pc_q    <= resp_pc_d;
         outst_q      <= outst_d;
         drop_q       <= drop_d;
         fault_pend_q <= fault_pend_d;
      end
   end

   rv32i_fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EW)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (fifo_push_s),
      .pop_i   (pop_s),
      .flush_i (redirect_valid),
      .wdata_i (fifo_wdata_s),
      .rdata_o (fifo_rdata_s),
      .count_o (fifo_count_s),
      .empty_o (fifo_empty_s),
      .full_o  (fifo_full_s)
   );

   assign imem_req_addr = pc_q;
   assign if_valid      = !fifo_empty_s;
   assign {if_misaligned, if_pc, if_instr} = fifo_rdata_s;

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Directed bench for rv32i_fetch_unit with a fixed-latency instruction memory model.
module tb_rv32i_fetch_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid, if_ready, if_misaligned;
   logic [31:0] if_instr, if_pc;

   always #5 clk = ~clk;

   rv32i_fetch_unit dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .if_misaligned  (if_misaligned)
   );

   typedef struct {
      logic        rdy;
      logic        rv;
      logic [31:0] rpc;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_ifv;
      logic [31:0] e_pc;
   } vec_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          lat      = 1;
   logic        pv [4];
   logic [31:0] pa [4];
   logic        s_acc;
   logic [31:0] s_addr;
   logic [31:0] req_log [$];
   logic [31:0] pop_pc  [$];
   logic [31:0] pop_ins [$];
   logic        pop_mis [$];
   vec_t        tv [23];

   function automatic logic [31:0] mw(input logic [31:0] a);
      return a ^ 32'hDEAD_0000;
   endfunction

   function automatic vec_t mkv(input logic rdy, input logic rv, input logic [31:0] rpc,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_ifv, input logic [31:0] e_pc);
      vec_t v;
      v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.e_req = e_req;
      v.e_addr = e_addr; v.e_ifv = e_ifv; v.e_pc = e_pc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic chk_pop(input int idx, input logic [31:0] pc, input logic [31:0] ins,
                          input logic mis);
      if (pop_pc.size() > idx) begin
         chk($sformatf("pop%0d pc", idx), pop_pc[idx], pc);
         chk($sformatf("pop%0d instr", idx), pop_ins[idx], ins);
         chk($sformatf("pop%0d misaligned", idx), 32'(pop_mis[idx]), 32'(mis));
      end else begin
         n_checks++;
         n_fail++;
         $display("FAIL pop%0d missing: got %0d pops, expected more than %0d", idx,
                  pop_pc.size(), idx);
      end
   endtask

   task automatic chk_req(input int idx, input logic [31:0] addr);
      if (req_log.size() > idx) begin
         chk($sformatf("req%0d addr", idx), req_log[idx], addr);
      end else begin
         n_checks++;
         n_fail++;
         $display("FAIL req%0d missing: got %0d requests, expected more than %0d", idx,
                  req_log.size(), idx);
      end
   endtask

   task automatic mem_clear();
      for (int i = 0; i < 4; i++) begin
         pv[i] = 1'b0;
         pa[i] = 32'h0;
      end
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
   endtask

   task automatic clear_logs();
      req_log.delete();
      pop_pc.delete();
      pop_ins.delete();
      pop_mis.delete();
   endtask

   // Drive the memory response for this cycle, settle and record handshakes.
   task automatic eval();
      imem_rsp_valid = pv[lat-1];
      imem_rsp_data  = mw(pa[lat-1]);
      #1;
      s_acc  = imem_req_valid && imem_req_ready;
      s_addr = imem_req_addr;
      if (s_acc) req_log.push_back(s_addr);
      if (if_valid && if_ready && !redirect_valid) begin
         pop_pc.push_back(if_pc);
         pop_ins.push_back(if_instr);
         pop_mis.push_back(if_misaligned);
      end
   endtask

   task automatic adv();
      @(posedge clk);
      for (int i = 3; i > 0; i--) begin
         pv[i] = pv[i-1];
         pa[i] = pa[i-1];
      end
      pv[0] = s_acc;
      pa[0] = s_addr;
      @(negedge clk);
   endtask

   task automatic cycle();
      eval();
      adv();
   endtask

   task automatic do_reset();
      reset_n        = 1'b0;
      if_ready       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      imem_req_ready = 1'b1;
      mem_clear();
      repeat (2) @(negedge clk);
      clear_logs();
      reset_n = 1'b1;
   endtask

   initial begin
      // Stream, stall, and redirect concurrent with pop + response (1-cycle memory).
      tv[0] = mkv(1'b1, 1'b0, 32'h0, 1'b1, 32'd0,  1'b0, 32'd0);
      tv[1] = mkv(1'b1, 1'b0, 32'h0, 1'b1, 32'd4,  1'b0, 32'd0);
      tv[2] = mkv(1'b1, 1'b0, 32'h0, 1'b1, 32'd8,  1'b1, 32'd0);
      tv[3] = mkv(1'b1, 1'b0, 32'h0, 1'b1, 32'd12, 1'b1, 32'd4);
      tv[4] = mkv(1'b1, 1'b0, 32'h0, 1'b1, 32'd16, 1'b1, 32'd8);
      tv[5] = mkv(1'b1, 1'b0, 32'h0, 1'b1, 32'd20, 1'b1, 32'd12);
      for (int k = 6; k < 16; k++) tv[k] = mkv(1'b0, 1'b0, 32'h0, 1'b0, 32'd24, 1'b1, 32'd16);
      tv[16] = mkv(1'b1, 1'b0, 32'h0,   1'b1, 32'd24,  1'b1, 32'd16);
      tv[17] = mkv(1'b1, 1'b0, 32'h0,   1'b1, 32'd28,  1'b1, 32'd20);
      tv[18] = mkv(1'b1, 1'b0, 32'h0,   1'b1, 32'd32,  1'b1, 32'd24);
      tv[19] = mkv(1'b1, 1'b1, 32'h100, 1'b0, 32'd36,  1'b1, 32'd28);
      tv[20] = mkv(1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'd0);
      tv[21] = mkv(1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'd0);
      tv[22] = mkv(1'b1, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h100);

      reset_n        = 1'b0;
      if_ready       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      imem_req_ready = 1'b1;
      mem_clear();
      repeat (2) @(negedge clk);
      #1;
      chk("rst req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst req_addr", imem_req_addr, 32'h0);
      chk("rst if_valid", 32'(if_valid), 32'd0);
      chk("rst if_instr", if_instr, 32'h0);
      chk("rst if_pc", if_pc, 32'h0);
      chk("rst if_misaligned", 32'(if_misaligned), 32'd0);
      @(negedge clk);
      clear_logs();
      reset_n = 1'b1;

      for (int k = 0; k < 23; k++) begin
         if_ready       = tv[k].rdy;
         redirect_valid = tv[k].rv;
         redirect_pc    = tv[k].rpc;
         eval();
         chk($sformatf("v%0d req_valid", k), 32'(imem_req_valid), 32'(tv[k].e_req));
         chk($sformatf("v%0d req_addr", k), imem_req_addr, tv[k].e_addr);
         chk($sformatf("v%0d if_valid", k), 32'(if_valid), 32'(tv[k].e_ifv));
         if (tv[k].e_ifv) begin
            chk($sformatf("v%0d if_pc", k), if_pc, tv[k].e_pc);
            chk($sformatf("v%0d if_instr", k), if_instr, mw(tv[k].e_pc));
            chk($sformatf("v%0d if_misaligned", k), 32'(if_misaligned), 32'd0);
         end
         adv();
      end
      redirect_valid = 1'b0;
      chk("stream pop count", 32'(pop_pc.size()), 32'd8);
      for (int i = 0; i < 7; i++) chk_pop(i, 32'(i * 4), mw(32'(i * 4)), 1'b0);
      chk_pop(7, 32'h100, mw(32'h100), 1'b0);

      // 3-cycle memory: redirect with two requests outstanding.
      do_reset();
      lat      = 3;
      if_ready = 1'b1;
      cycle();
      cycle();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      eval();
      chk("lat3 redirect req_valid", 32'(imem_req_valid), 32'd0);
      adv();
      redirect_valid = 1'b0;
      repeat (15) cycle();
      chk_req(0, 32'h0);
      chk_req(1, 32'h4);
      chk_req(2, 32'h100);
      chk_req(3, 32'h104);
      chk_pop(0, 32'h100, mw(32'h100), 1'b0);
      chk_pop(1, 32'h104, mw(32'h104), 1'b0);

      // Misaligned redirect produces one fault marker and halts fetch.
      do_reset();
      lat      = 1;
      if_ready = 1'b1;
      cycle();
      cycle();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h102;
      cycle();
      redirect_valid = 1'b0;
      repeat (6) cycle();
      chk("fault req count", 32'(req_log.size()), 32'd2);
      chk("fault pop count", 32'(pop_pc.size()), 32'd1);
      chk_pop(0, 32'h102, 32'h0000_0013, 1'b1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      cycle();
      redirect_valid = 1'b0;
      repeat (6) cycle();
      chk_req(2, 32'h200);
      chk_pop(1, 32'h200, mw(32'h200), 1'b0);

      // Asynchronous reset in mid-stream, then restart from the reset PC.
      do_reset();
      if_ready = 1'b1;
      repeat (5) cycle();
      eval();
      #2;
      reset_n = 1'b0;
      #1;
      chk("async req_valid", 32'(imem_req_valid), 32'd0);
      chk("async req_addr", imem_req_addr, 32'h0);
      chk("async if_valid", 32'(if_valid), 32'd0);
      chk("async if_instr", if_instr, 32'h0);
      chk("async if_pc", if_pc, 32'h0);
      chk("async if_misaligned", 32'(if_misaligned), 32'd0);
      @(negedge clk);
      mem_clear();
      @(negedge clk);
      clear_logs();
      reset_n = 1'b1;
      repeat (4) cycle();
      chk_req(0, 32'h0);
      chk_req(1, 32'h4);
      chk_pop(0, 32'h0, mw(32'h0), 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
